// File: rtl/branch_sequencer_if.sv
// Decode-side control bundle between the sequencer and its partner logic.
// Carries the fetched word and zero flag in, and branch/execute controls out.
interface branch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int LOOP_W = 8
);
  logic [7:0]        instr;
  logic              zero_flag;
  logic              Branch;
  logic [ADDR_W-1:0] jump_value;
  logic              exec_valid;
  logic [LOOP_W-1:0] loop_count;

  modport master (
    output instr,
    output zero_flag,
    input  Branch,
    input  jump_value,
    input  exec_valid,
    input  loop_count
  );

  modport slave (
    input  instr,
    input  zero_flag,
    output Branch,
    output jump_value,
    output exec_valid,
    output loop_count
  );
endinterface

// File: rtl/branch_sequencer.sv
// Resolves BEQ/LOOP/DJNZ control flow for the program counter and
// squashes the single wrong-path word fetched behind each taken branch.
module branch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int OFF_W  = 6,
  parameter int LOOP_W = 8
) (
  input logic           clk,
  input logic           reset,
  branch_sequencer_if.slave bus
);
  logic              sq_q, sq_d;
  logic [LOOP_W-1:0] lc_q, lc_d;
  logic [LOOP_W-1:0] lc_dec;
  logic [OFF_W-1:0]  imm;
  logic [ADDR_W-1:0] imm_sx;
  logic              exec;
  logic              br;
  logic              is_beq, is_loop, is_djnz;

  assign imm     = bus.instr[OFF_W-1:0];
  assign imm_sx  = {{(ADDR_W-OFF_W){imm[OFF_W-1]}}, imm};
  assign lc_dec  = lc_q - 1'b1;
  assign exec    = !sq_q && !reset;
  assign is_beq  = exec && (bus.instr[7:6] == 2'b01);
  assign is_loop = exec && (bus.instr[7:6] == 2'b10);
  assign is_djnz = exec && (bus.instr[7:6] == 2'b11);

  always_comb begin
    br   = 1'b0;
    lc_d = lc_q;
    unique case (1'b1)
      is_beq: br = bus.zero_flag;
      is_loop: lc_d = LOOP_W'(imm);
      is_djnz: begin
        if (lc_q != '0) begin
          lc_d = lc_dec;
          br   = (lc_dec != '0);
        end
      end
      default: ;
    endcase
    if (reset) lc_d = '0;
  end

  // Counter already points at A+1, so the displacement drops one.
  assign bus.Branch     = br;
  assign bus.jump_value = br ? (imm_sx - 1'b1) : '0;
  assign bus.exec_valid = exec;
  assign bus.loop_count = lc_q;

  assign sq_d = reset ? 1'b1 : br;

  always_ff @(posedge clk) begin
    sq_q <= sq_d;
    lc_q <= lc_d;
  end
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: reset, BEQ, LOOP/DJNZ, wrap,
// and reset during a squash cycle.
module tb_branch_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  branch_sequencer_if #(.ADDR_W(8), .LOOP_W(8)) bus ();

  branch_sequencer #(.ADDR_W(8), .OFF_W(6), .LOOP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] i, input logic z,
                       input logic r);
    @(negedge clk);
    bus.instr     = i;
    bus.zero_flag = z;
    reset         = r;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic b,
                      input logic [7:0] jv, input logic ev);
    chk({tag, "_br"}, 32'(bus.Branch), 32'(b));
    chk({tag, "_jv"}, 32'(bus.jump_value), 32'(jv));
    chk({tag, "_ev"}, 32'(bus.exec_valid), 32'(ev));
  endtask

  initial begin
    bus.instr     = 8'h00;
    bus.zero_flag = 1'b0;
    reset         = 1'b1;

    // reset held two cycles, a BEQ with zero set must not fire
    drive(8'h44, 1'b1, 1'b1);
    chk3("rst1", 1'b0, 8'h00, 1'b0);
    drive(8'h44, 1'b1, 1'b1);
    chk3("rst2", 1'b0, 8'h00, 1'b0);
    drive(8'h44, 1'b1, 1'b0);
    chk3("post1", 1'b0, 8'h00, 1'b0);
    chk("post1_lc", 32'(bus.loop_count), 32'h0);
    drive(8'h00, 1'b0, 1'b0);
    chk3("post2", 1'b0, 8'h00, 1'b1);

    // BEQ +4 at 0x10 taken
    drive(8'h44, 1'b1, 1'b0);
    chk3("beq_t", 1'b1, 8'h03, 1'b1);
    chk("beq_tgt", 32'(8'(8'h11 + bus.jump_value + 8'h01)), 32'h15);
    drive(8'h44, 1'b1, 1'b0);
    chk3("beq_sq", 1'b0, 8'h00, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    chk3("beq_after", 1'b0, 8'h00, 1'b1);

    // BEQ not taken: no bubble
    drive(8'h44, 1'b0, 1'b0);
    chk3("beq_nt", 1'b0, 8'h00, 1'b1);
    drive(8'h00, 1'b0, 1'b0);
    chk3("beq_nt_next", 1'b0, 8'h00, 1'b1);

    // LOOP 3 then DJNZ -1 at 0x21
    drive(8'h83, 1'b0, 1'b0);
    chk3("loop", 1'b0, 8'h00, 1'b1);
    drive(8'hFF, 1'b0, 1'b0);
    chk("dj1_lc", 32'(bus.loop_count), 32'd3);
    chk3("dj1", 1'b1, 8'hFE, 1'b1);
    chk("dj1_tgt", 32'(8'(8'h22 + bus.jump_value + 8'h01)), 32'h21);
    drive(8'hFF, 1'b0, 1'b0);
    chk("dj1s_lc", 32'(bus.loop_count), 32'd2);
    chk3("dj1s", 1'b0, 8'h00, 1'b0);
    drive(8'hFF, 1'b0, 1'b0);
    chk("dj2_lc", 32'(bus.loop_count), 32'd2);
    chk3("dj2", 1'b1, 8'hFE, 1'b1);
    drive(8'hFF, 1'b0, 1'b0);
    chk("dj2s_lc", 32'(bus.loop_count), 32'd1);
    chk3("dj2s", 1'b0, 8'h00, 1'b0);
    drive(8'hFF, 1'b0, 1'b0);
    chk("dj3_lc", 32'(bus.loop_count), 32'd1);
    chk3("dj3", 1'b0, 8'h00, 1'b1);

    // DJNZ at zero saturates
    drive(8'hFF, 1'b0, 1'b0);
    chk("dj0_lc", 32'(bus.loop_count), 32'd0);
    chk3("dj0", 1'b0, 8'h00, 1'b1);
    drive(8'h00, 1'b0, 1'b0);
    chk("dj0_after_lc", 32'(bus.loop_count), 32'd0);

    // LOOP 5, then BEQ -4 at 0x01 wrapping to 0xFE
    drive(8'h85, 1'b0, 1'b0);
    chk3("loop5", 1'b0, 8'h00, 1'b1);
    drive(8'h7C, 1'b1, 1'b0);
    chk("wrap_lc", 32'(bus.loop_count), 32'd5);
    chk3("wrap", 1'b1, 8'hFB, 1'b1);
    chk("wrap_tgt", 32'(8'(8'h02 + bus.jump_value + 8'h01)), 32'hFE);

    // reset during squash cycle
    drive(8'h7C, 1'b1, 1'b1);
    chk3("rsq", 1'b0, 8'h00, 1'b0);
    drive(8'h7C, 1'b1, 1'b0);
    chk("rsq1_lc", 32'(bus.loop_count), 32'd0);
    chk3("rsq1", 1'b0, 8'h00, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    chk3("rsq2", 1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Decode-side partner of the program counter.
- Consumes the instruction word returned by the synchronous instruction ROM (one-cycle read latency) and resolves control flow.
- Drives the counter's `Branch` and `jump_value` inputs, maintains a hardware loop counter, and squashes the wrong-path instruction fetched during a taken branch.
- Tells the datapath which instructions to execute via `exec_valid`.

Parameters:
- `ADDR_W`, 8, width of `jump_value` and of address arithmetic; matches the counter's address width.
- `OFF_W`, 6, width of the signed branch offset field in the instruction.
- `LOOP_W`, 8, width of the internal loop counter.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `instr`  input  8  ROM data out; holds the word for the address the counter presented in the previous cycle.
- `zero_flag`  input  1  ALU zero flag, valid in the same cycle as `instr`.
- `Branch`  output  1  to counter; 1 = load address + `jump_value` + 1 at the next edge.
- `jump_value`  output  `ADDR_W`  to counter; branch displacement.
- `exec_valid`  output  1  current `instr` is architecturally valid; datapath executes it only when 1.
- `loop_count`  output  `LOOP_W`  current loop counter value, for observation.

Behaviour:
- **Instruction format.**
  - `instr[7:6]` is the opcode; `instr[5:0]` is the immediate `imm`.
  - `00` NOP/ALU: no control action.
  - `01` BEQ: branch if `zero_flag` = 1.
  - `10` LOOP: `loop_count <= {2'b0, imm}`.
  - `11` DJNZ: if `loop_count` != 0, then `loop_count <= loop_count - 1` and branch if `(loop_count - 1)` != 0.
  - If `loop_count` = 0 on DJNZ: no decrement (saturates at 0) and no branch.
- **Target rule.** For an instruction fetched from address A, target = A + 1 + sext(`imm`), modulo 2^`ADDR_W`.
  - When `instr` is visible, the counter already holds A+1.
  - Therefore `jump_value` = sext(`imm`) - 1, truncated to `ADDR_W` bits.
  - Example: `imm` = 0 gives `jump_value` = 8'hFF, target A+1.
- **Branch timing.** `Branch` is combinational from `instr`, `zero_flag`, `loop_count` and the squash state. It is asserted only when `exec_valid` = 1 and the branch condition holds.
- **`jump_value` when idle.** When `Branch` = 0, `jump_value` = 0.
- **Squash state** (1-bit register `sq`).
  - `exec_valid` = !`sq`.
  - Next `sq` = 1 if `Branch` = 1 this cycle; otherwise 0.
  - While `sq` = 1, the current `instr` is the wrong-path word (A+1). It causes no branch, no loop-counter update and `exec_valid` = 0.
  - Consequence: exactly one bubble per taken branch; back-to-back branch instructions in the wrong path are ignored.
- **Reset.**
  - During a cycle with `reset` = 1: `sq` <= 1 and `loop_count` <= 0.
  - Outputs while `reset` is high: `Branch` = 0, `jump_value` = 0, `exec_valid` = 0.
  - The first cycle after reset is squashed, because the ROM output is stale.
  - Reset asserted mid-loop or mid-squash overrides all other updates.
- **Loop counter arithmetic.** Unsigned, `LOOP_W` bits. LOOP zero-extends `imm`. Only LOOP and DJNZ with `exec_valid` = 1 modify it.
- **Address wrap-around.** Handled by modular arithmetic in the counter. Negative offsets from A = 0 are legal and wrap (e.g. target 8'hFD).

Test Plan:
- Reset held 2 cycles, then released → `exec_valid` = 0 in the first cycle after release and 1 in the second; `loop_count` = 0; `Branch` = 0 throughout.
- BEQ `imm` = +4 at A = 8'h10 with `zero_flag` = 1 → `Branch` = 1, `jump_value` = 8'h03; counter next address = 8'h15. Word at 8'h11 is squashed: `exec_valid` = 0 and no `Branch` even though it is BEQ.
- Same BEQ with `zero_flag` = 0 → `Branch` = 0, no bubble, the next instruction executes.
- LOOP `imm` = 3, then DJNZ `imm` = -1 at A = 8'h21 → `loop_count` sequence 3, 2, 1, 0. `Branch` = 1 on the first two DJNZ executions with `jump_value` = 8'hFE (target 8'h21). No branch on the third. Fall-through to 8'h22.
- DJNZ with `loop_count` = 0 → `loop_count` stays 0, `Branch` = 0.
- BEQ `imm` = -4 at A = 8'h01 → `jump_value` = 8'hFB, counter target 8'hFE (wrap). Reset asserted during the following squash cycle → `loop_count` cleared, `exec_valid` = 0 in the reset cycle and the first cycle after.
